// File: rtl/adc_uart_sequencer_pkg.sv
// adc_uart_sequencer_pkg: shared state encoding, frame constants and hex-to-ASCII helper
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADC_WAIT = 2'd1,
        TX_WAIT  = 2'd2
    } state_e;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam int         FRAME_LEN = 4;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/adc_uart_sequencer_if.sv
// adc_uart_sequencer_if: ADC request/result and UART byte handshake bundle
interface adc_uart_sequencer_if;

    logic       adc_start;
    logic       adc_done;
    logic [7:0] adc_data;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_done;

    modport master (
        output adc_start, tx_data, tx_load,
        input  adc_done, adc_data, tx_done
    );

    modport slave (
        input  adc_start, tx_data, tx_load,
        output adc_done, adc_data, tx_done
    );

endinterface

// File: rtl/adc_uart_sequencer_hex_ascii_enc.sv
// hex_ascii_enc: combinational 4-bit nibble to uppercase ASCII hex digit
module hex_ascii_enc
    import adc_seq_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    assign ascii_o = hex_ascii(nib_i);

endmodule

// File: rtl/adc_uart_sequencer.sv
// adc_uart_sequencer: triggers one ADC conversion and streams {hex_hi, hex_lo, CR, LF} to the UART; ADC_SEQ_AUTO_EN adds a periodic trigger
module adc_uart_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned ADC_TIMEOUT_CYC = 1000,
    parameter int unsigned PERIOD_CYC      = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        auto_en_i,
    adc_uart_sequencer_if.master        bus,
    output logic [7:0]                  sample_o,
    output logic                        sample_valid_o,
    output logic                        busy_o,
    output logic                        overrun_o,
    output logic                        timeout_err_o
);

    localparam int unsigned TW = $clog2(ADC_TIMEOUT_CYC + 1);

    state_e         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]     sample_q, sample_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           adc_start_q, adc_start_d;
    logic           tx_load_q, tx_load_d;
    logic           sample_valid_q, sample_valid_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;
    logic           timeout_err_q, timeout_err_d;
    logic           trig;
    logic [3:0]     nib;
    logic [7:0]     hex_c;

`ifdef ADC_SEQ_AUTO_EN
    localparam int unsigned PW = $clog2(PERIOD_CYC + 1);

    logic [PW-1:0]  per_cnt_q, per_cnt_d;
    logic           tick;

    assign tick      = auto_en_i && per_cnt_q == PW'(PERIOD_CYC - 1);
    assign per_cnt_d = (!auto_en_i || tick) ? '0 : per_cnt_q + 1'b1;
    assign trig      = start_i | tick;

    // period counter: free-runs while auto_en is high, held at zero otherwise
    always_ff @(posedge clk) begin
        if (rst) per_cnt_q <= '0;
        else     per_cnt_q <= per_cnt_d;
    end
`else
    localparam int unsigned unused_period = PERIOD_CYC;
    logic unused_auto;

    assign unused_auto = auto_en_i;
    assign trig        = start_i;
`endif

    // the single encoder sees the high nibble while capturing, the low nibble afterwards
    assign nib = (state_q == ADC_WAIT) ? bus.adc_data[7:4] : sample_q[3:0];

    hex_ascii_enc u_enc (
        .nib_i   (nib),
        .ascii_o (hex_c)
    );

    // next-state and registered-output decode
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        to_cnt_d       = to_cnt_q;
        sample_d       = sample_q;
        tx_data_d      = tx_data_q;
        adc_start_d    = 1'b0;
        tx_load_d      = 1'b0;
        sample_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        overrun_d      = trig && state_q != IDLE;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d     = ADC_WAIT;
                    adc_start_d = 1'b1;
                    to_cnt_d    = '0;
                end
            end
            ADC_WAIT: begin
                if (bus.adc_done) begin
                    sample_d       = bus.adc_data;
                    sample_valid_d = 1'b1;
                    tx_data_d      = hex_c;
                    tx_load_d      = 1'b1;
                    idx_d          = 2'd0;
                    state_d        = TX_WAIT;
                end else if (to_cnt_q == TW'(ADC_TIMEOUT_CYC - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            TX_WAIT: begin
                if (bus.tx_done) begin
                    if (idx_q == 2'(FRAME_LEN - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_load_d = 1'b1;
                        tx_data_d = (idx_q == 2'd0) ? hex_c : (idx_q == 2'd1) ? CHAR_CR : CHAR_LF;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            to_cnt_q       <= '0;
            sample_q       <= '0;
            tx_data_q      <= '0;
            adc_start_q    <= 1'b0;
            tx_load_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            to_cnt_q       <= to_cnt_d;
            sample_q       <= sample_d;
            tx_data_q      <= tx_data_d;
            adc_start_q    <= adc_start_d;
            tx_load_q      <= tx_load_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign bus.adc_start  = adc_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_load    = tx_load_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign busy_o         = busy_q;
    assign overrun_o      = overrun_q;
    assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_adc_uart_sequencer.sv
// tb_adc_uart_sequencer: directed scoreboard bench for adc_uart_sequencer
module tb_adc_uart_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] sample;
    logic       sample_valid, busy, overrun, timeout_err;

    int errors = 0;
    int checks = 0;
    int loads  = 0;
    int starts = 0;
    int cyc    = 0;
    logic [7:0] exp_q[$];

    adc_uart_sequencer_if bus ();

    adc_uart_sequencer #(
        .ADC_TIMEOUT_CYC (16),
        .PERIOD_CYC      (100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .auto_en_i      (auto_en),
        .bus            (bus),
        .sample_o       (sample),
        .sample_valid_o (sample_valid),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .timeout_err_o  (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mhex(input logic [3:0] n);
        return (n > 4'd9) ? 8'd65 + 8'(n) - 8'd10 : 8'd48 + 8'(n);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every tx_load pops one expected byte
    initial forever begin
        @(negedge clk);
        if (bus.adc_start === 1'b1) starts++;
        if (bus.tx_load === 1'b1) begin
            loads++;
            if (exp_q.size() == 0) check("tx_load_unexpected", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
            else check("tx_data", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("adc_start", {31'h0, bus.adc_start}, 32'd1);
        check("busy_on", {31'h0, busy}, 32'd1);
    endtask

    task automatic wait_load();
        int n;
        n = 0;
        while (bus.tx_load !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_load_seen", {31'h0, bus.tx_load}, 32'd1);
    endtask

    task automatic serve_frame(input logic [7:0] d, input bit ovr);
        logic [7:0] ch[4];
        int l0, s0;
        ch[0] = mhex(d[7:4]);
        ch[1] = mhex(d[3:0]);
        ch[2] = 8'h0D;
        ch[3] = 8'h0A;
        l0 = loads;
        s0 = starts;
        for (int i = 0; i < 4; i++) exp_q.push_back(ch[i]);
        bus.adc_data = d;
        bus.adc_done = 1'b1;
        @(negedge clk);
        bus.adc_done = 1'b0;
        check("sample_valid", {31'h0, sample_valid}, 32'd1);
        check("sample", {24'h0, sample}, {24'h0, d});
        check("no_timeout", {31'h0, timeout_err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_load();
            tick_n(2);
            check("tx_hold", {24'h0, bus.tx_data}, {24'h0, ch[i]});
            if (ovr && i == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("overrun", {31'h0, overrun}, 32'd1);
                check("no_adc_start", {31'h0, bus.adc_start}, 32'd0);
                @(negedge clk);
                check("overrun_pulse", {31'h0, overrun}, 32'd0);
            end
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
        end
        check("busy_end", {31'h0, busy}, 32'd0);
        @(negedge clk);
        check("loads", loads - l0, 32'd4);
        check("single_start", starts - s0, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_frame(input logic [7:0] d, input int lat, input bit ovr);
        pulse_start();
        tick_n(lat);
        serve_frame(d, ovr);
    endtask

    initial begin
        int first, tcount, l0, s0;
        int stamp[3];
        bus.adc_done = 1'b0;
        bus.adc_data = 8'h00;
        bus.tx_done  = 1'b0;
        tick_n(3);
        check("rst_adc_start", {31'h0, bus.adc_start}, 32'd0);
        check("rst_tx_load", {31'h0, bus.tx_load}, 32'd0);
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'd0);
        check("rst_sample", {24'h0, sample}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_flags", {29'h0, sample_valid, overrun, timeout_err}, 32'd0);
        rst = 1'b0;
        tick_n(2);

        do_frame(8'h3C, 10, 1'b0);
        do_frame(8'h81, 15, 1'b0);

        pulse_start();
        first  = -1;
        tcount = 0;
        l0     = loads;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                tcount++;
                if (first < 0) begin
                    first = j;
                    check("busy_after_timeout", {31'h0, busy}, 32'd0);
                end
            end
        end
        check("timeout_cycles", first, 32'd16);
        check("timeout_pulses", tcount, 32'd1);
        check("timeout_no_load", loads - l0, 32'd0);
        check("timeout_sample_kept", {24'h0, sample}, 32'h81);

        s0 = starts;
        do_frame(8'h9B, 6, 1'b1);
        check("overrun_one_start", starts - s0, 32'd1);

        do_frame(8'hF0, 4, 1'b0);
        l0 = loads;
        bus.adc_data = 8'h55;
        bus.adc_done = 1'b1;
        @(negedge clk);
        bus.adc_done = 1'b0;
        bus.tx_done  = 1'b1;
        @(negedge clk);
        bus.tx_done  = 1'b0;
        check("idle_sv", {31'h0, sample_valid}, 32'd0);
        check("idle_busy", {31'h0, busy}, 32'd0);
        tick_n(3);
        check("idle_sample", {24'h0, sample}, 32'hF0);
        check("idle_no_load", loads - l0, 32'd0);

        pulse_start();
        tick_n(5);
        exp_q.push_back(mhex(4'hA));
        exp_q.push_back(mhex(4'h7));
        bus.adc_data = 8'hA7;
        bus.adc_done = 1'b1;
        @(negedge clk);
        bus.adc_done = 1'b0;
        wait_load();
        tick_n(2);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        wait_load();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_adc_start", {31'h0, bus.adc_start}, 32'd0);
        check("mid_rst_tx_load", {31'h0, bus.tx_load}, 32'd0);
        check("mid_rst_tx_data", {24'h0, bus.tx_data}, 32'd0);
        check("mid_rst_sample", {24'h0, sample}, 32'd0);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_flags", {29'h0, sample_valid, overrun, timeout_err}, 32'd0);
        rst = 1'b0;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        tick_n(3);
        check("post_rst_idle", {31'h0, busy}, 32'd0);
        check("post_rst_queue", exp_q.size(), 32'd0);
        do_frame(8'h5E, 8, 1'b0);

`ifdef ADC_SEQ_AUTO_EN
        auto_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            first = 0;
            while (bus.adc_start !== 1'b1 && first < 150) begin
                @(negedge clk);
                first++;
            end
            check("auto_start_seen", {31'h0, bus.adc_start}, 32'd1);
            stamp[f] = cyc;
            serve_frame(8'h10 + 8'(f), 1'b0);
        end
        check("auto_period_1", stamp[1] - stamp[0], 32'd100);
        check("auto_period_2", stamp[2] - stamp[1], 32'd100);
        auto_en = 1'b0;
        s0 = starts;
        tick_n(250);
        check("auto_off", starts - s0, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
